md_unit: RTL and testbench

//  Parametrised multi-cycle multiply/divide unit with HI/LO registers; EX-stage companion to the 5-stage pipeline.

---
 rtl/md_unit_if.sv | 32 +++
 rtl/md_unit.sv | 169 ++++++++++++++++
 tb/tb_md_unit.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/md_unit_if.sv
// md_unit_if: bus between the EX stage and the multiply/divide unit.
//   start  : op valid this cycle
//   op     : 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 no-op
//   a, b   : rs / rt operands
//   rd_sel : 0 selects LO onto rdata, 1 selects HI
//   rdata  : HI or LO per rd_sel (combinational)
//   hi, lo : architectural HI/LO registers
//   busy   : multi-cycle operation in flight
// master = EX / hazard side, slave = md_unit.
interface md_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             rd_sel;
  logic [WIDTH-1:0] rdata;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;

  modport master (
    output start, op, a, b, rd_sel,
    input  rdata, hi, lo, busy
  );

  modport slave (
    input  start, op, a, b, rd_sel,
    output rdata, hi, lo, busy
  );
endinterface

// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit with HI/LO registers, sitting
// beside the EX stage. The result is computed from the operands on the
// accepting edge and parked in pending registers; a down-counter models the
// configured latency and HI/LO are written when it reaches its last cycle.
//
// Ports:
//   clk   : clock, all state on rising edge
//   reset : synchronous, active-high; aborts an op in flight
//   bus   : md_unit_if slave modport (start/op/a/b/rd_sel in,
//           rdata/hi/lo/busy out)
//
// state  | meaning
// IDLE   | no op in flight, busy=0, accepts any op
// RUN    | mult/div in flight, busy=1, cnt = remaining cycles
module md_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  md_unit_if.slave   bus
);

  localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] pend_hi_q, pend_hi_d;
  logic [WIDTH-1:0] pend_lo_q, pend_lo_d;
  logic             pend_wr_q, pend_wr_d;

  // Arithmetic datapath, evaluated on the current operands.
  logic [2*WIDTH-1:0] mul_a, mul_b, prod;
  logic               div_signed, a_neg, b_neg;
  logic [WIDTH-1:0]   ua, ub, ub_safe, uq, ur, quo, rem;

  always_comb begin
    mul_a      = '0;
    mul_b      = '0;
    prod       = '0;
    div_signed = 1'b0;
    a_neg      = 1'b0;
    b_neg      = 1'b0;
    ua         = '0;
    ub         = '0;
    ub_safe    = '0;
    uq         = '0;
    ur         = '0;
    quo        = '0;
    rem        = '0;

    // Sign/zero-extend to 2*WIDTH so a plain unsigned multiply yields the
    // correct low 2*WIDTH bits for both MULT and MULTU.
    if (bus.op == OP_MULT) begin
      mul_a = {{WIDTH{bus.a[WIDTH-1]}}, bus.a};
      mul_b = {{WIDTH{bus.b[WIDTH-1]}}, bus.b};
    end else begin
      mul_a = {{WIDTH{1'b0}}, bus.a};
      mul_b = {{WIDTH{1'b0}}, bus.b};
    end
    prod = mul_a * mul_b;

    // Signed divide done on magnitudes. |most negative| is representable
    // as an unsigned WIDTH-bit value, so most_negative / -1 naturally
    // gives quotient = a and remainder = 0 without any special case.
    div_signed = (bus.op == OP_DIV);
    a_neg      = div_signed & bus.a[WIDTH-1];
    b_neg      = div_signed & bus.b[WIDTH-1];
    ua         = a_neg ? -bus.a : bus.a;
    ub         = b_neg ? -bus.b : bus.b;
    // Divide-by-zero results are discarded; keep the divider well-defined.
    ub_safe    = (ub == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : ub;
    uq         = ua / ub_safe;
    ur         = ua % ub_safe;
    quo        = (a_neg ^ b_neg) ? -uq : uq;
    rem        = a_neg ? -ur : ur;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          case (bus.op)
            OP_MULT, OP_MULTU: begin
              pend_hi_d = prod[2*WIDTH-1:WIDTH];
              pend_lo_d = prod[WIDTH-1:0];
              pend_wr_d = 1'b1;
              cnt_d     = CW'(MULT_CYCLES);
              state_d   = S_RUN;
            end
            OP_DIV, OP_DIVU: begin
              pend_hi_d = rem;
              pend_lo_d = quo;
              pend_wr_d = (bus.b != '0);
              cnt_d     = CW'(DIV_CYCLES);
              state_d   = S_RUN;
            end
            OP_MTHI: hi_d = bus.a;
            OP_MTLO: lo_d = bus.a;
            default: ;
          endcase
        end
      end
      S_RUN: begin
        // start is ignored here; the hazard unit keeps it from happening.
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d   = S_IDLE;
          pend_wr_d = 1'b0;
          if (pend_wr_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_wr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
    end
  end

  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;
  assign bus.busy  = (state_q == S_RUN);
  assign bus.rdata = bus.rd_sel ? hi_q : lo_q;

endmodule

// File: tb/tb_md_unit.sv
module tb_md_unit;

  logic clk = 1'b0;
  logic reset;
  logic rst16;

  always #5 clk = ~clk;

  md_unit_if #(.WIDTH(32)) bus32 ();
  md_unit_if #(.WIDTH(16)) bus16 ();

  md_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus32)
  );

  md_unit #(.WIDTH(16), .MULT_CYCLES(1), .DIV_CYCLES(1)) u_dut16 (
    .clk   (clk),
    .reset (rst16),
    .bus   (bus16)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
    int          tag;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  int   run_cnt[2];
  bit   busy_prev[2];
  bit   mt_prev[2];
  bit   rst_prev[2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor step, run on every falling edge per DUT instance. An output is
  // presented when busy falls (not caused by reset) or one cycle after an
  // accepted MTHI/MTLO.
  task automatic mon_step(input int g, input logic busy, input logic rst,
                          input logic mt_now, input logic [31:0] hi, input logic [31:0] lo);
    exp_t e;
    if (busy) run_cnt[g]++;
    if (!rst && !rst_prev[g] && ((busy_prev[g] && !busy) || mt_prev[g])) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_output inst %0d: got hi=%h lo=%h expected no output", g, hi, lo);
      end else begin
        e = sb.pop_front();
        check($sformatf("hi[%0d]", e.tag), hi, e.hi);
        check($sformatf("lo[%0d]", e.tag), lo, e.lo);
        check($sformatf("busy_cycles[%0d]", e.tag), 32'(run_cnt[g]), 32'(e.cycles));
      end
      run_cnt[g] = 0;
    end
    if (rst) run_cnt[g] = 0;
    busy_prev[g] = busy;
    mt_prev[g]   = mt_now && !busy && !rst;
    rst_prev[g]  = rst;
  endtask

  always @(negedge clk)
    mon_step(0, bus32.busy, reset, bus32.start && (bus32.op == 3'd4 || bus32.op == 3'd5),
             bus32.hi, bus32.lo);

  always @(negedge clk)
    mon_step(1, bus16.busy, rst16, bus16.start && (bus16.op == 3'd4 || bus16.op == 3'd5),
             32'(bus16.hi), 32'(bus16.lo));

  task automatic push(input logic [31:0] h, input logic [31:0] l, input int cyc, input int tag);
    exp_t e;
    e.hi = h; e.lo = l; e.cycles = cyc; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic wait_idle(input int g);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (((g == 0) ? bus32.busy : bus16.busy) == 1'b0) return;
    end
    n_cmp++;
    n_bad++;
    $display("FAIL idle_timeout inst %0d: busy still 1 after 40 cycles, expected 0", g);
  endtask

  task automatic drive32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus32.start = 1'b1;
    bus32.op    = op;
    bus32.a     = a;
    bus32.b     = b;
    @(posedge clk);
    #1;
    bus32.start = 1'b0;
    bus32.a     = $urandom;
    bus32.b     = $urandom;
  endtask

  task automatic run32(input int tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eh, input logic [31:0] el);
    int cyc;
    cyc = (op <= 3'd1) ? 5 : (op <= 3'd3) ? 10 : 0;
    push(eh, el, cyc, tag);
    drive32(op, a, b);
    wait_idle(0);
  endtask

  task automatic drive16(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    bus16.start = 1'b1;
    bus16.op    = op;
    bus16.a     = a;
    bus16.b     = b;
    @(posedge clk);
    #1;
    bus16.start = 1'b0;
    bus16.a     = 16'($urandom);
    bus16.b     = 16'($urandom);
  endtask

  initial begin
    logic [2:0]  op;
    logic [15:0] a16, b16, m_hi, m_lo;
    logic [31:0] pu;
    int          p, sa, sb_i, qi, ri;

    reset = 1'b1;
    rst16 = 1'b1;
    bus32.start = 1'b0; bus32.op = 3'd7; bus32.a = '0; bus32.b = '0; bus32.rd_sel = 1'b0;
    bus16.start = 1'b0; bus16.op = 3'd7; bus16.a = '0; bus16.b = '0; bus16.rd_sel = 1'b0;

    // Reset held for two edges
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_hi", bus32.hi, 32'h0);
    check("rst_lo", bus32.lo, 32'h0);
    check("rst_busy", 32'(bus32.busy), 32'h0);
    bus32.rd_sel = 1'b0; #1;
    check("rst_rdata_lo", bus32.rdata, 32'h0);
    bus32.rd_sel = 1'b1; #1;
    check("rst_rdata_hi", bus32.rdata, 32'h0);
    @(posedge clk); #1;

    // Multiply / divide directed vectors
    run32(1, 3'd0, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB);
    run32(2, 3'd1, 32'hFFFFFFFD, 32'd7, 32'h00000006, 32'hFFFFFFEB);
    run32(3, 3'd2, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run32(4, 3'd3, 32'd7,        32'd2, 32'h00000001, 32'h00000003);
    run32(5, 3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
    run32(6, 3'd2, 32'h00000064, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFF2); // 100 / -7

    // Divide by zero keeps preloaded HI/LO
    run32(7, 3'd4, 32'h11, 32'h0, 32'h00000011, 32'hFFFFFFF2);
    run32(8, 3'd5, 32'h22, 32'h0, 32'h00000011, 32'h00000022);
    run32(9, 3'd3, 32'h5,  32'h0, 32'h00000011, 32'h00000022);

    // Back-to-back MTHI / MTLO
    push(32'hDEADBEEF, 32'h00000022, 0, 10);
    push(32'hDEADBEEF, 32'h12345678, 0, 11);
    bus32.start = 1'b1; bus32.op = 3'd4; bus32.a = 32'hDEADBEEF;
    @(posedge clk); #1;
    bus32.op = 3'd5; bus32.a = 32'h12345678;
    @(posedge clk); #1;
    bus32.start = 1'b0;
    @(negedge clk);
    bus32.rd_sel = 1'b1; #1;
    check("mt_rdata_hi", bus32.rdata, 32'hDEADBEEF);
    bus32.rd_sel = 1'b0; #1;
    check("mt_rdata_lo", bus32.rdata, 32'h12345678);
    @(posedge clk); #1;

    // Reset on cycle 4 of a DIV: aborted, no late write
    drive32(3'd2, 32'd100, 32'd7);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(bus32.busy), 32'h0);
    check("abort_hi", bus32.hi, 32'h0);
    check("abort_lo", bus32.lo, 32'h0);
    repeat (12) @(negedge clk);
    check("abort_late_hi", bus32.hi, 32'h0);
    check("abort_late_lo", bus32.lo, 32'h0);
    check("abort_late_busy", 32'(bus32.busy), 32'h0);
    @(posedge clk); #1;

    // Start while busy is ignored
    push(32'h0, 32'h0000000C, 5, 12);
    drive32(3'd0, 32'd3, 32'd4);
    @(posedge clk); #1;
    drive32(3'd3, 32'd100, 32'd7);
    wait_idle(0);
    repeat (12) @(negedge clk);
    check("ign_hi", bus32.hi, 32'h0);
    check("ign_lo", bus32.lo, 32'h0000000C);

    // 16-bit, single-cycle instance against a behavioural model
    @(posedge clk); #1;
    rst16 = 1'b0;
    m_hi = '0;
    m_lo = '0;
    @(posedge clk); #1;
    for (int i = 0; i < 1000; i++) begin
      op  = 3'($urandom_range(0, 7));
      a16 = 16'($urandom);
      b16 = 16'($urandom);
      case ($urandom_range(0, 9))
        0: b16 = 16'h0;
        1: begin a16 = 16'h8000; b16 = 16'hFFFF; end
        2: b16 = 16'($urandom_range(1, 5));
        default: ;
      endcase
      case (op)
        3'd0: begin
          p = int'($signed(a16)) * int'($signed(b16));
          m_hi = p[31:16];
          m_lo = p[15:0];
        end
        3'd1: begin
          pu = 32'(a16) * 32'(b16);
          m_hi = pu[31:16];
          m_lo = pu[15:0];
        end
        3'd2: if (b16 != 16'h0) begin
          sa = int'($signed(a16));
          sb_i = int'($signed(b16));
          qi = sa / sb_i;
          ri = sa % sb_i;
          m_lo = qi[15:0];
          m_hi = ri[15:0];
        end
        3'd3: if (b16 != 16'h0) begin
          m_lo = a16 / b16;
          m_hi = a16 % b16;
        end
        3'd4: m_hi = a16;
        3'd5: m_lo = a16;
        default: ;
      endcase
      if (op <= 3'd5) push(32'(m_hi), 32'(m_lo), (op <= 3'd3) ? 1 : 0, 1000 + i);
      drive16(op, a16, b16);
      wait_idle(1);
      @(posedge clk); #1;
    end
    repeat (3) @(negedge clk);
    check("w16_final_hi", 32'(bus16.hi), 32'(m_hi));
    check("w16_final_lo", 32'(bus16.lo), 32'(m_lo));

    check("sb_empty", 32'(sb.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
